// File: rtl/ibex_cheri_scr_file_pkg.sv
// Shared types and constants for the CHERI special capability register file.
// Holds the SCR numbering, access ops, CHERI exception causes and MCCSR layout.
package ibex_cheri_scr_file_pkg;

    typedef enum logic [1:0] {
        SCR_NONE      = 2'd0,
        SCR_READ      = 2'd1,
        SCR_WRITE     = 2'd2,
        SCR_READWRITE = 2'd3
    } scr_op_e;

    typedef enum logic [4:0] {
        SCR_PCC       = 5'd0,
        SCR_DDC       = 5'd1,
        SCR_UTCC      = 5'd4,
        SCR_UTDC      = 5'd5,
        SCR_USCRATCHC = 5'd6,
        SCR_UEPCC     = 5'd7,
        SCR_STCC      = 5'd12,
        SCR_STDC      = 5'd13,
        SCR_SSCRATCHC = 5'd14,
        SCR_SEPCC     = 5'd15,
        SCR_MTCC      = 5'd28,
        SCR_MTDC      = 5'd29,
        SCR_MSCRATCHC = 5'd30,
        SCR_MEPCC     = 5'd31
    } scr_num_e;

    typedef enum logic [4:0] {
        CAUSE_NONE                            = 5'h00,
        CAUSE_LENGTH_VIOLATION                = 5'h01,
        CAUSE_TAG_VIOLATION                   = 5'h02,
        CAUSE_SEAL_VIOLATION                  = 5'h03,
        CAUSE_TYPE_VIOLATION                  = 5'h04,
        CAUSE_PERMIT_EXECUTE_VIOLATION        = 5'h11,
        CAUSE_PERMIT_LOAD_VIOLATION           = 5'h12,
        CAUSE_PERMIT_STORE_VIOLATION          = 5'h13,
        CAUSE_ACCESS_SYSTEM_REGISTERS_VIOLATION = 5'h18
    } c_exc_cause_e;

    typedef enum logic {
        SCR_IDLE = 1'b0,
        SCR_RESP = 1'b1
    } scr_fsm_e;

    localparam int unsigned MCCSR_E_BIT     = 0;
    localparam int unsigned MCCSR_D_BIT     = 1;
    localparam int unsigned MCCSR_CAUSE_LSB = 5;
    localparam int unsigned MCCSR_IDX_LSB   = 10;

endpackage

// File: rtl/ibex_cheri_scr_file_decode.sv
// Address/permission decode for an SCR access: which registers exist,
// which need ACCESS_SYSTEM_REGISTERS, and the resulting fault flags.
module ibex_cheri_scr_file_decode
    import ibex_cheri_scr_file_pkg::*;
(
    input  logic [4:0] scr_addr_i,
    input  logic       pcc_asr_i,
    output logic       implemented_o,
    output logic       privileged_o,
    output logic       illegal_o,
    output logic       cheri_fault_o
);

    always_comb begin
        implemented_o = 1'b0;
        privileged_o  = 1'b0;
        unique case (scr_addr_i)
            SCR_DDC: begin
                implemented_o = 1'b1;
            end
            SCR_MTCC, SCR_MTDC, SCR_MSCRATCHC, SCR_MEPCC: begin
                implemented_o = 1'b1;
                privileged_o  = 1'b1;
            end
            default: begin
                implemented_o = 1'b0;
                privileged_o  = 1'b0;
            end
        endcase
    end

    // An unimplemented address never raises a permission fault.
    assign illegal_o     = ~implemented_o;
    assign cheri_fault_o = implemented_o & privileged_o & ~pcc_asr_i;

endmodule

// File: rtl/ibex_cheri_scr_file.sv
// CHERI special capability register file: serves CSpecialRW accesses with a
// fixed one-cycle response, captures PCC/cause on traps, exports DDC/MTCC/MEPCC.
module ibex_cheri_scr_file
    import ibex_cheri_scr_file_pkg::*;
#(
    parameter int unsigned      CAP_W    = 93,
    parameter logic [CAP_W-1:0] DDC_RST  = {1'b1, {(CAP_W-1){1'b0}}},
    parameter logic [CAP_W-1:0] MTCC_RST = {1'b1, {(CAP_W-1){1'b0}}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [1:0]       scr_op_i,
    input  logic [4:0]       scr_addr_i,
    input  logic [CAP_W-1:0] wdata_i,
    input  logic             pcc_asr_i,
    output logic             rvalid_o,
    output logic [CAP_W-1:0] rdata_o,
    output logic             err_illegal_o,
    output logic             err_cheri_o,
    output logic [4:0]       err_cause_o,
    output logic [5:0]       err_idx_o,
    input  logic             trap_i,
    input  logic [CAP_W-1:0] trap_pcc_i,
    input  logic             trap_cheri_i,
    input  logic [4:0]       trap_cause_i,
    input  logic [5:0]       trap_idx_i,
    output logic [CAP_W-1:0] ddc_o,
    output logic [CAP_W-1:0] mtcc_o,
    output logic [CAP_W-1:0] mepcc_o,
    output logic [31:0]      mccsr_o
);

    scr_fsm_e         state_q;
    logic [CAP_W-1:0] ddc_q, ddc_d, mtcc_q, mtcc_d, mtdc_q, mtdc_d;
    logic [CAP_W-1:0] mscratchc_q, mscratchc_d, mepcc_q, mepcc_d;
    logic [4:0]       mccsr_cause_q, mccsr_cause_d;
    logic [5:0]       mccsr_idx_q, mccsr_idx_d;
    logic             mccsr_dbit_q, mccsr_dbit_d;

    logic             rvalid_q, err_illegal_q, err_cheri_q;
    logic [CAP_W-1:0] rdata_q, rdata_d;
    logic             err_illegal_d, err_cheri_d;
    logic [4:0]       err_cause_q, err_cause_d;
    logic [5:0]       err_idx_q, err_idx_d;

    logic             implemented, privileged, illegal, cheri_fault;
    logic             accept, op_active, op_rd, op_wr, access_ok, we;
    logic [CAP_W-1:0] old_val;
    scr_op_e          op;

    ibex_cheri_scr_file_decode u_decode (
        .scr_addr_i    (scr_addr_i),
        .pcc_asr_i     (pcc_asr_i),
        .implemented_o (implemented),
        .privileged_o  (privileged),
        .illegal_o     (illegal),
        .cheri_fault_o (cheri_fault)
    );

    assign op        = scr_op_e'(scr_op_i);
    assign gnt_o     = (state_q == SCR_IDLE) & ~trap_i;
    assign accept    = req_i & gnt_o;
    assign op_active = (op != SCR_NONE);
    assign op_rd     = (op == SCR_READ) | (op == SCR_READWRITE);
    assign op_wr     = (op == SCR_WRITE) | (op == SCR_READWRITE);
    assign access_ok = accept & op_active & ~illegal & ~cheri_fault;
    assign we        = access_ok & op_wr;

    always_comb begin
        old_val = '0;
        unique case (scr_addr_i)
            SCR_DDC:       old_val = ddc_q;
            SCR_MTCC:      old_val = mtcc_q;
            SCR_MTDC:      old_val = mtdc_q;
            SCR_MSCRATCHC: old_val = mscratchc_q;
            SCR_MEPCC:     old_val = mepcc_q;
            default:       old_val = '0;
        endcase
    end

    always_comb begin
        ddc_d         = ddc_q;
        mtcc_d        = mtcc_q;
        mtdc_d        = mtdc_q;
        mscratchc_d   = mscratchc_q;
        mepcc_d       = mepcc_q;
        mccsr_cause_d = mccsr_cause_q;
        mccsr_idx_d   = mccsr_idx_q;
        mccsr_dbit_d  = mccsr_dbit_q;
        if (we) begin
            unique case (scr_addr_i)
                SCR_DDC:       ddc_d       = wdata_i;
                SCR_MTCC:      mtcc_d      = wdata_i;
                SCR_MTDC:      mtdc_d      = wdata_i;
                SCR_MSCRATCHC: mscratchc_d = wdata_i;
                SCR_MEPCC:     mepcc_d     = wdata_i;
                default:       ddc_d       = ddc_q;
            endcase
        end
        // gnt_o is low during a trap, so a trap never races a write here.
        if (trap_i) begin
            mepcc_d = trap_pcc_i;
            if (trap_cheri_i) begin
                mccsr_cause_d = trap_cause_i;
                mccsr_idx_d   = trap_idx_i;
                mccsr_dbit_d  = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d       = (access_ok & op_rd) ? old_val : '0;
        err_illegal_d = accept & op_active & illegal;
        err_cheri_d   = accept & op_active & ~illegal & cheri_fault;
        err_cause_d   = err_cheri_d ? CAUSE_ACCESS_SYSTEM_REGISTERS_VIOLATION : CAUSE_NONE;
        err_idx_d     = err_cheri_d ? {1'b1, scr_addr_i} : 6'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= SCR_IDLE;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_illegal_q <= 1'b0;
            err_cheri_q   <= 1'b0;
            err_cause_q   <= CAUSE_NONE;
            err_idx_q     <= 6'd0;
        end else begin
            unique case (state_q)
                SCR_IDLE: if (accept) state_q <= SCR_RESP;
                SCR_RESP: state_q <= SCR_IDLE;
                default:  state_q <= SCR_IDLE;
            endcase
            rvalid_q      <= accept;
            rdata_q       <= rdata_d;
            err_illegal_q <= err_illegal_d;
            err_cheri_q   <= err_cheri_d;
            err_cause_q   <= err_cause_d;
            err_idx_q     <= err_idx_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ddc_q         <= DDC_RST;
            mtcc_q        <= MTCC_RST;
            mtdc_q        <= '0;
            mscratchc_q   <= '0;
            mepcc_q       <= '0;
            mccsr_cause_q <= CAUSE_NONE;
            mccsr_idx_q   <= 6'd0;
            mccsr_dbit_q  <= 1'b0;
        end else begin
            ddc_q         <= ddc_d;
            mtcc_q        <= mtcc_d;
            mtdc_q        <= mtdc_d;
            mscratchc_q   <= mscratchc_d;
            mepcc_q       <= mepcc_d;
            mccsr_cause_q <= mccsr_cause_d;
            mccsr_idx_q   <= mccsr_idx_d;
            mccsr_dbit_q  <= mccsr_dbit_d;
        end
    end

    always_comb begin
        mccsr_o                          = 32'd0;
        mccsr_o[MCCSR_E_BIT]             = 1'b1;
        mccsr_o[MCCSR_D_BIT]             = mccsr_dbit_q;
        mccsr_o[MCCSR_CAUSE_LSB +: 5]    = mccsr_cause_q;
        mccsr_o[MCCSR_IDX_LSB +: 6]      = mccsr_idx_q;
    end

    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign err_illegal_o = err_illegal_q;
    assign err_cheri_o   = err_cheri_q;
    assign err_cause_o   = err_cause_q;
    assign err_idx_o     = err_idx_q;
    assign ddc_o         = ddc_q;
    assign mtcc_o        = mtcc_q;
    assign mepcc_o       = mepcc_q;

endmodule

// File: tb/tb_ibex_cheri_scr_file.sv
// Directed bench for ibex_cheri_scr_file: request handshake, permission and
// illegal-address faults, trap capture and reset during a response.
module tb_ibex_cheri_scr_file;

    localparam int unsigned      CAP_W    = 93;
    localparam logic [CAP_W-1:0] ROOT_CAP = {1'b1, {(CAP_W-1){1'b0}}};

    localparam logic [1:0] OP_NONE = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_RW = 2'd3;
    localparam logic [4:0] A_PCC = 5'd0, A_DDC = 5'd1, A_UTCC = 5'd4, A_MTCC = 5'd28;
    localparam logic [4:0] A_MTDC = 5'd29, A_MSCR = 5'd30, A_MEPCC = 5'd31;

    typedef struct {
        logic             granted;
        logic             gnt_in_resp;
        logic             rvalid;
        logic [CAP_W-1:0] rdata;
        logic             err_illegal;
        logic             err_cheri;
        logic [4:0]       err_cause;
        logic [5:0]       err_idx;
        logic [CAP_W-1:0] ddc;
        logic [CAP_W-1:0] mtcc;
        logic [CAP_W-1:0] mepcc;
    } resp_t;

    logic             clk, rst;
    logic             req, gnt;
    logic [1:0]       scr_op;
    logic [4:0]       scr_addr;
    logic [CAP_W-1:0] wdata;
    logic             pcc_asr;
    logic             rvalid;
    logic [CAP_W-1:0] rdata;
    logic             err_illegal, err_cheri;
    logic [4:0]       err_cause;
    logic [5:0]       err_idx;
    logic             trap;
    logic [CAP_W-1:0] trap_pcc;
    logic             trap_cheri;
    logic [4:0]       trap_cause;
    logic [5:0]       trap_idx;
    logic [CAP_W-1:0] ddc, mtcc, mepcc;
    logic [31:0]      mccsr;

    int n_checks = 0;
    int n_fail   = 0;

    ibex_cheri_scr_file #(
        .CAP_W    (CAP_W),
        .DDC_RST  (ROOT_CAP),
        .MTCC_RST (ROOT_CAP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .gnt_o         (gnt),
        .scr_op_i      (scr_op),
        .scr_addr_i    (scr_addr),
        .wdata_i       (wdata),
        .pcc_asr_i     (pcc_asr),
        .rvalid_o      (rvalid),
        .rdata_o       (rdata),
        .err_illegal_o (err_illegal),
        .err_cheri_o   (err_cheri),
        .err_cause_o   (err_cause),
        .err_idx_o     (err_idx),
        .trap_i        (trap),
        .trap_pcc_i    (trap_pcc),
        .trap_cheri_i  (trap_cheri),
        .trap_cause_i  (trap_cause),
        .trap_idx_i    (trap_idx),
        .ddc_o         (ddc),
        .mtcc_o        (mtcc),
        .mepcc_o       (mepcc),
        .mccsr_o       (mccsr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: issue one request, wait (bounded) for grant, sample the response cycle.
    task automatic req_txn(input logic [1:0] op, input logic [4:0] addr,
                           input logic [CAP_W-1:0] wd, input logic asr, output resp_t r);
        int n;
        r = '{default: '0};
        scr_op = op; scr_addr = addr; wdata = wd; pcc_asr = asr; req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!gnt && n < 10) begin
            @(negedge clk);
            n++;
        end
        r.granted = gnt;
        @(posedge clk);
        @(negedge clk);
        r.gnt_in_resp = gnt;
        r.rvalid      = rvalid;
        r.rdata       = rdata;
        r.err_illegal = err_illegal;
        r.err_cheri   = err_cheri;
        r.err_cause   = err_cause;
        r.err_idx     = err_idx;
        r.ddc         = ddc;
        r.mtcc        = mtcc;
        r.mepcc       = mepcc;
        @(posedge clk);
        #1;
        req = 1'b0;
        scr_op = OP_NONE;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_checks++; if ({err_illegal, err_cheri, err_cause, err_idx} !== 13'd0) begin n_fail++; $display("FAIL reset_err: got %b%b %h %h want 0", err_illegal, err_cheri, err_cause, err_idx); end
        n_checks++; if (ddc !== ROOT_CAP) begin n_fail++; $display("FAIL reset_ddc: got %h want %h", ddc, ROOT_CAP); end
        n_checks++; if (mtcc !== ROOT_CAP) begin n_fail++; $display("FAIL reset_mtcc: got %h want %h", mtcc, ROOT_CAP); end
        n_checks++; if (mepcc !== '0) begin n_fail++; $display("FAIL reset_mepcc: got %h want 0", mepcc); end
        n_checks++; if (mccsr !== 32'h1) begin n_fail++; $display("FAIL reset_mccsr: got %h want 00000001", mccsr); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL idle_gnt: got %b want 1", gnt); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ddc_read();
        resp_t r;
        req_txn(OP_READ, A_DDC, '0, 1'b0, r);
        n_checks++; if (r.granted !== 1'b1) begin n_fail++; $display("FAIL ddc_read_gnt: got %b want 1", r.granted); end
        n_checks++; if (r.rvalid !== 1'b1) begin n_fail++; $display("FAIL ddc_read_rvalid: got %b want 1", r.rvalid); end
        n_checks++; if (r.gnt_in_resp !== 1'b0) begin n_fail++; $display("FAIL ddc_read_resp_gnt: got %b want 0", r.gnt_in_resp); end
        n_checks++; if (r.rdata !== ROOT_CAP) begin n_fail++; $display("FAIL ddc_read_rdata: got %h want %h", r.rdata, ROOT_CAP); end
        n_checks++; if ({r.err_illegal, r.err_cheri} !== 2'b00) begin n_fail++; $display("FAIL ddc_read_err: got %b%b want 00", r.err_illegal, r.err_cheri); end
        @(negedge clk);
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL ddc_read_one_cycle: got %b want 0", rvalid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_scratch_rw();
        resp_t r;
        req_txn(OP_RW, A_MSCR, 93'h1_2345, 1'b1, r);
        n_checks++; if (r.rvalid !== 1'b1 || r.rdata !== '0) begin n_fail++; $display("FAIL mscr_rw_old: got v=%b %h want v=1 0", r.rvalid, r.rdata); end
        n_checks++; if ({r.err_illegal, r.err_cheri} !== 2'b00) begin n_fail++; $display("FAIL mscr_rw_err: got %b%b want 00", r.err_illegal, r.err_cheri); end
        req_txn(OP_READ, A_MSCR, '0, 1'b1, r);
        n_checks++; if (r.rdata !== 93'h1_2345) begin n_fail++; $display("FAIL mscr_readback: got %h want 12345", r.rdata); end
    endtask

    task automatic test_ddc_write();
        resp_t r;
        req_txn(OP_WRITE, A_DDC, 93'hBEEF, 1'b0, r);
        n_checks++; if (r.rdata !== '0) begin n_fail++; $display("FAIL ddc_write_rdata: got %h want 0", r.rdata); end
        n_checks++; if (r.ddc !== 93'hBEEF) begin n_fail++; $display("FAIL ddc_write_visible: got %h want beef", r.ddc); end
        req_txn(OP_READ, A_DDC, '0, 1'b0, r);
        n_checks++; if (r.rdata !== 93'hBEEF) begin n_fail++; $display("FAIL ddc_readback: got %h want beef", r.rdata); end
    endtask

    task automatic test_mtcc_priv();
        resp_t r;
        req_txn(OP_WRITE, A_MTCC, 93'h5555, 1'b0, r);
        n_checks++; if (r.rvalid !== 1'b1 || r.err_cheri !== 1'b1 || r.err_illegal !== 1'b0) begin n_fail++; $display("FAIL mtcc_priv_err: got v=%b c=%b i=%b want 1 1 0", r.rvalid, r.err_cheri, r.err_illegal); end
        n_checks++; if (r.err_cause !== 5'h18) begin n_fail++; $display("FAIL mtcc_priv_cause: got %h want 18", r.err_cause); end
        n_checks++; if (r.err_idx !== 6'h3C) begin n_fail++; $display("FAIL mtcc_priv_idx: got %h want 3c", r.err_idx); end
        n_checks++; if (r.mtcc !== ROOT_CAP) begin n_fail++; $display("FAIL mtcc_priv_unchanged: got %h want %h", r.mtcc, ROOT_CAP); end
        req_txn(OP_RW, A_MTCC, 93'h7777, 1'b1, r);
        n_checks++; if (r.rdata !== ROOT_CAP || r.mtcc !== 93'h7777 || r.err_cheri !== 1'b0) begin n_fail++; $display("FAIL mtcc_rw_ok: got %h %h c=%b want root 7777 0", r.rdata, r.mtcc, r.err_cheri); end
    endtask

    task automatic test_illegal();
        resp_t r;
        req_txn(OP_READ, A_UTCC, '0, 1'b0, r);
        n_checks++; if (r.err_illegal !== 1'b1 || r.err_cheri !== 1'b0) begin n_fail++; $display("FAIL utcc_illegal: got i=%b c=%b want 1 0", r.err_illegal, r.err_cheri); end
        n_checks++; if (r.rdata !== '0 || r.err_cause !== 5'h0) begin n_fail++; $display("FAIL utcc_rdata: got %h cause %h want 0 0", r.rdata, r.err_cause); end
        req_txn(OP_WRITE, A_PCC, 93'h99, 1'b1, r);
        n_checks++; if (r.err_illegal !== 1'b1 || r.ddc !== 93'hBEEF || r.mepcc !== '0) begin n_fail++; $display("FAIL pcc_illegal: got i=%b ddc=%h mepcc=%h want 1 beef 0", r.err_illegal, r.ddc, r.mepcc); end
        req_txn(OP_NONE, A_MTCC, 93'h1, 1'b0, r);
        n_checks++; if (r.rvalid !== 1'b1 || {r.err_illegal, r.err_cheri} !== 2'b00 || r.mtcc !== 93'h7777) begin n_fail++; $display("FAIL scr_none: got v=%b err=%b%b mtcc=%h want 1 00 7777", r.rvalid, r.err_illegal, r.err_cheri, r.mtcc); end
    endtask

    task automatic test_trap();
        resp_t r;
        scr_op = OP_READ; scr_addr = A_DDC; pcc_asr = 1'b0; req = 1'b1;
        trap = 1'b1; trap_pcc = 93'hABC; trap_cheri = 1'b1; trap_cause = 5'h02; trap_idx = 6'd7;
        @(negedge clk);
        n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL trap_gnt: got %b want 0", gnt); end
        @(posedge clk);
        #1;
        trap = 1'b0; req = 1'b0;
        @(negedge clk);
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL trap_no_accept: got %b want 0", rvalid); end
        n_checks++; if (mepcc !== 93'hABC) begin n_fail++; $display("FAIL trap_mepcc: got %h want abc", mepcc); end
        n_checks++; if (mccsr !== 32'h1C43) begin n_fail++; $display("FAIL trap_mccsr: got %h want 00001c43", mccsr); end
        @(posedge clk);
        #1;
        trap = 1'b1; trap_pcc = 93'h777; trap_cheri = 1'b0; trap_cause = 5'h03; trap_idx = 6'd9;
        @(posedge clk);
        #1;
        trap = 1'b0;
        @(negedge clk);
        n_checks++; if (mepcc !== 93'h777 || mccsr !== 32'h1C43) begin n_fail++; $display("FAIL trap_nocheri: got %h %h want 777 00001c43", mepcc, mccsr); end
        @(posedge clk);
        #1;
        req_txn(OP_READ, A_MEPCC, '0, 1'b1, r);
        n_checks++; if (r.rdata !== 93'h777) begin n_fail++; $display("FAIL mepcc_read: got %h want 777", r.rdata); end
    endtask

    task automatic test_trap_in_resp();
        resp_t r;
        scr_op = OP_WRITE; scr_addr = A_MTDC; wdata = 93'h3210; pcc_asr = 1'b1; req = 1'b1;
        @(posedge clk);
        #1;
        trap = 1'b1; trap_pcc = 93'h555; trap_cheri = 1'b0;
        @(negedge clk);
        n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL trap_resp_rvalid: got %b want 1", rvalid); end
        @(posedge clk);
        #1;
        trap = 1'b0; req = 1'b0;
        @(negedge clk);
        n_checks++; if (mepcc !== 93'h555 || rvalid !== 1'b0) begin n_fail++; $display("FAIL trap_resp_after: got mepcc=%h v=%b want 555 0", mepcc, rvalid); end
        @(posedge clk);
        #1;
        req_txn(OP_READ, A_MTDC, '0, 1'b1, r);
        n_checks++; if (r.rdata !== 93'h3210) begin n_fail++; $display("FAIL trap_resp_write_kept: got %h want 3210", r.rdata); end
    endtask

    task automatic test_back_to_back();
        resp_t r;
        scr_op = OP_READ; scr_addr = A_MSCR; pcc_asr = 1'b1; req = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (gnt !== 1'b1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_regrant: got gnt=%b v=%b want 1 0", gnt, rvalid); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (rvalid !== 1'b1 || rdata !== 93'h1_2345) begin n_fail++; $display("FAIL b2b_second: got v=%b %h want 1 12345", rvalid, rdata); end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic test_reset_mid_resp();
        resp_t r;
        scr_op = OP_WRITE; scr_addr = A_DDC; wdata = 93'h42; pcc_asr = 1'b0; req = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (rvalid !== 1'b1 || ddc !== 93'h42) begin n_fail++; $display("FAIL mid_resp_pre: got v=%b ddc=%h want 1 42", rvalid, ddc); end
        rst = 1'b1;
        #1;
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_resp_rvalid: got %b want 0", rvalid); end
        n_checks++; if (ddc !== ROOT_CAP || mtcc !== ROOT_CAP || mepcc !== '0 || mccsr !== 32'h1) begin n_fail++; $display("FAIL mid_resp_regs: got %h %h %h %h want root root 0 1", ddc, mtcc, mepcc, mccsr); end
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_txn(OP_READ, A_MSCR, '0, 1'b1, r);
        n_checks++; if (r.rdata !== '0) begin n_fail++; $display("FAIL mid_resp_mscr: got %h want 0", r.rdata); end
        req_txn(OP_READ, A_MTDC, '0, 1'b1, r);
        n_checks++; if (r.rdata !== '0) begin n_fail++; $display("FAIL mid_resp_mtdc: got %h want 0", r.rdata); end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; scr_op = OP_NONE; scr_addr = '0; wdata = '0; pcc_asr = 1'b0;
        trap = 1'b0; trap_pcc = '0; trap_cheri = 1'b0; trap_cause = '0; trap_idx = '0;
        test_reset();
        test_ddc_read();
        test_scratch_rw();
        test_ddc_write();
        test_mtcc_priv();
        test_illegal();
        test_trap();
        test_trap_in_resp();
        test_back_to_back();
        test_reset_mid_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
